// File: rtl/float_fxp_pkg.sv
// Shared constants, FSM state type and sizing helper for the float-to-fixed converter.
package float_fxp_pkg;

  localparam int EXP_W      = 8;
  localparam int MANT_W     = 23;
  localparam int BIAS       = 127;
  localparam int MAG_IN_W   = MANT_W + 1;
  localparam int RSHIFT_MAX = 26;
  localparam int AMT_W      = 6;

  localparam logic [EXP_W-1:0] EXP_ZERO    = '0;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  // Magnitude register must hold the 24-bit significand plus a rounding carry.
  function automatic int mag_width(input int out_w);
    return (out_w > MAG_IN_W + 1) ? out_w : MAG_IN_W + 1;
  endfunction

endpackage

// File: rtl/fxp_step_shifter.sv
// One shift step of up to STEP bit positions, left or right, reporting the last bit dropped on a right shift.
module fxp_step_shifter
  import float_fxp_pkg::*;
#(
  parameter int W    = 32,
  parameter int STEP = 4
) (
  input  logic [W-1:0]     din,
  input  logic [AMT_W-1:0] amt,
  input  logic             left,
  output logic [W-1:0]     dout,
  output logic             guard,
  output logic [AMT_W-1:0] amt_rem,
  output logic             last
);

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  logic [AMT_W-1:0] step;
  logic [W-1:0]     pre;

  always_comb begin
    step  = (amt > STEP_A) ? STEP_A : amt;
    pre   = '0;
    dout  = din;
    guard = 1'b0;
    if (left) begin
      dout = din << step;
    end else if (step != '0) begin
      // Stop one bit short so the final dropped bit lands in pre[0].
      pre   = din >> (step - AMT_W'(1));
      guard = pre[0];
      dout  = pre >> 1;
    end
    amt_rem = amt - step;
    last    = (amt_rem == '0);
  end

endmodule

// File: rtl/float_to_fxp_param.sv
// Multi-cycle IEEE-754 single to signed fixed-point converter with saturation, NaN flag and optional rounding.
module float_to_fxp_param
  import float_fxp_pkg::*;
#(
  parameter int OUT_W      = 32,
  parameter int FRAC_W     = 16,
  parameter int SHIFT_STEP = 4,
  parameter int ROUND_EN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      float_in,
  output logic [OUT_W-1:0] fxp_out,
  output logic             ready,
  output logic             busy,
  output logic             ovf,
  output logic             nan
);

  localparam int MAG_W = mag_width(OUT_W);
  localparam int KOFF  = BIAS + MANT_W - FRAC_W;
  localparam int LSAT  = OUT_W - 1 - MAG_IN_W;

  localparam logic [MAG_W:0]   MAXPOS  = {{(MAG_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  state_t state, state_nxt;

  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic [MAG_W-1:0]  mag_q;
  logic [AMT_W-1:0]  amt_q;
  logic              left_q, guard_q;
  logic              frc_zero_q, frc_sat_q, frc_nan_q;
  logic [OUT_W-1:0]  res_q;
  logic              res_ovf_q, res_nan_q;

  logic signed [10:0] k;
  logic [10:0]        kneg;
  logic               dec_zero, dec_nan, dec_sat, dec_left, dec_force;
  logic [AMT_W-1:0]   dec_amt;

  logic [MAG_W-1:0] sh_dout;
  logic             sh_guard, sh_last;
  logic [AMT_W-1:0] sh_rem;

  logic             rnd_bit;
  logic [MAG_W:0]   rmag;
  logic [OUT_W-1:0] rnd_res;
  logic             rnd_ovf, rnd_nan;
  logic             accept;

  always_comb begin
    k         = $signed({3'b000, exp_q}) - $signed(11'(KOFF));
    kneg      = -k;
    dec_zero  = (exp_q == EXP_ZERO);
    dec_nan   = (exp_q == EXP_SPECIAL) && (mant_q != '0);
    dec_sat   = !dec_zero && !dec_nan &&
                ((exp_q == EXP_SPECIAL) || (!k[10] && (k > $signed(11'(LSAT)))));
    dec_force = dec_zero | dec_nan | dec_sat;
    dec_left  = !k[10];
    if (!k[10]) begin
      dec_amt = AMT_W'(k);
    end else if (kneg > 11'(RSHIFT_MAX)) begin
      dec_amt = AMT_W'(RSHIFT_MAX);
    end else begin
      dec_amt = AMT_W'(kneg);
    end
  end

  fxp_step_shifter #(
    .W    (MAG_W),
    .STEP (SHIFT_STEP)
  ) u_shift (
    .din     (mag_q),
    .amt     (amt_q),
    .left    (left_q),
    .dout    (sh_dout),
    .guard   (sh_guard),
    .amt_rem (sh_rem),
    .last    (sh_last)
  );

  always_comb begin
    rnd_bit = (ROUND_EN != 0) && guard_q;
    rmag    = {1'b0, mag_q} + {{MAG_W{1'b0}}, rnd_bit};
    rnd_res = '0;
    rnd_ovf = 1'b0;
    rnd_nan = 1'b0;
    if (frc_nan_q) begin
      rnd_nan = 1'b1;
    end else if (frc_zero_q) begin
      rnd_res = '0;
    end else if (frc_sat_q || (rmag > MAXPOS)) begin
      rnd_res = sign_q ? SAT_NEG : SAT_POS;
      rnd_ovf = 1'b1;
    end else begin
      rnd_res = sign_q ? -rmag[OUT_W-1:0] : rmag[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (dec_force || (dec_amt == '0)) ? S_ROUND : S_SHIFT;
      S_SHIFT:  if (sh_last) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   state_nxt = start ? S_DECODE : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state == S_DECODE) || (state == S_SHIFT) || (state == S_ROUND);

  // Result is staged in ROUND and published while leaving DONE, so ready
  // rises on the same edge that can accept a back-to-back operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sign_q, exp_q, mant_q} <= '0;
      mag_q      <= '0;
      amt_q      <= '0;
      left_q     <= 1'b0;
      guard_q    <= 1'b0;
      frc_zero_q <= 1'b0;
      frc_sat_q  <= 1'b0;
      frc_nan_q  <= 1'b0;
      res_q      <= '0;
      res_ovf_q  <= 1'b0;
      res_nan_q  <= 1'b0;
      fxp_out    <= '0;
      ovf        <= 1'b0;
      nan        <= 1'b0;
      ready      <= 1'b0;
    end else begin
      ready <= (state == S_DONE);
      if (accept) {sign_q, exp_q, mant_q} <= float_in;
      unique case (state)
        S_DECODE: begin
          mag_q      <= {{(MAG_W-MAG_IN_W){1'b0}}, 1'b1, mant_q};
          amt_q      <= dec_amt;
          left_q     <= dec_left;
          guard_q    <= 1'b0;
          frc_zero_q <= dec_zero;
          frc_nan_q  <= dec_nan;
          frc_sat_q  <= dec_sat;
        end
        S_SHIFT: begin
          mag_q   <= sh_dout;
          amt_q   <= sh_rem;
          guard_q <= sh_guard;
        end
        S_ROUND: begin
          res_q     <= rnd_res;
          res_ovf_q <= rnd_ovf;
          res_nan_q <= rnd_nan;
        end
        S_DONE: begin
          fxp_out <= res_q;
          ovf     <= res_ovf_q;
          nan     <= res_nan_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_fxp_param.sv
// Scoreboard bench: two converter configurations against a real-arithmetic reference model.
module tb_float_to_fxp_param;

  localparam int W1 = 32, F1 = 16, S1 = 4, R1 = 1;
  localparam int W2 = 40, F2 = 16, S2 = 8, R2 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;
  logic [31:0] fin1 = '0, fin2 = '0;
  logic [W1-1:0] out1;
  logic [W2-1:0] out2;
  logic rdy1, busy1, ovf1, nan1;
  logic rdy2, busy2, ovf2, nan2;

  typedef struct {
    longint      val;
    bit          ovf;
    bit          nan;
    int          lat;
    longint      acc;
    logic [31:0] op;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  float_to_fxp_param #(.OUT_W(W1), .FRAC_W(F1), .SHIFT_STEP(S1), .ROUND_EN(R1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .float_in(fin1),
    .fxp_out(out1), .ready(rdy1), .busy(busy1), .ovf(ovf1), .nan(nan1)
  );

  float_to_fxp_param #(.OUT_W(W2), .FRAC_W(F2), .SHIFT_STEP(S2), .ROUND_EN(R2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .float_in(fin2),
    .fxp_out(out2), .ready(rdy2), .busy(busy2), .ovf(ovf2), .nan(nan2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL global_timeout: got no end of test, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  function automatic real pow2(input int p);
    real r = 1.0;
    if (p >= 0) for (int i = 0; i < p; i++) r = r * 2.0;
    else        for (int i = 0; i < -p; i++) r = r / 2.0;
    return r;
  endfunction

  // Value-level model: |x| * 2^fw rounded (or truncated), then saturated.
  function automatic exp_t model(input logic [31:0] f, input int ow, input int fw,
                                 input int st, input bit re);
    exp_t   r;
    bit     s    = f[31];
    int     e    = int'(f[30:23]);
    int     m    = int'(f[22:0]);
    longint maxp = (longint'(1) << (ow - 1)) - 1;
    int     k    = e - (150 - fw);
    int     n;
    real    x, mr;
    r.val = 0; r.ovf = 0; r.nan = 0; r.lat = 3; r.acc = 0; r.op = f;
    if (e == 255) begin
      if (m != 0) r.nan = 1;
      else        r.ovf = 1;
    end else if (e != 0) begin
      if (k >= 0 && k + 24 > ow - 1) begin
        r.ovf = 1;
      end else begin
        n = (k >= 0) ? k : ((-k > 26) ? 26 : -k);
        r.lat = 3 + (n + st - 1) / st;
        x  = (1.0 + real'(m) / 8388608.0) * pow2(e - 127) * pow2(fw);
        mr = re ? $floor(x + 0.5) : $floor(x);
        if (mr > real'(maxp)) r.ovf = 1;
        else r.val = s ? -longint'(mr) : longint'(mr);
      end
    end
    if (r.ovf) r.val = s ? (-maxp - 1) : maxp;
    return r;
  endfunction

  function automatic logic [31:0] rand_float();
    int sel = int'($urandom_range(0, 9));
    logic [31:0] f = $urandom;
    if (sel < 7) begin
      f[30:23] = 8'($urandom_range(100, 160));
    end else if (sel == 7) begin
      f[30:23] = 8'($urandom_range(0, 1));
    end else if (sel == 8) begin
      f[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 1) f[22:0] = '0;
    end
    return f;
  endfunction

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && rdy1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_ready: got fxp 0x%0h, required no result", out1);
      end else begin
        e = q1.pop_front();
        chk($sformatf("dut1_fxp[%08h]", e.op), longint'($signed(out1)), e.val);
        chk($sformatf("dut1_ovf[%08h]", e.op), longint'(ovf1), longint'(e.ovf));
        chk($sformatf("dut1_nan[%08h]", e.op), longint'(nan1), longint'(e.nan));
        chk($sformatf("dut1_latency[%08h]", e.op), cyc - e.acc, longint'(e.lat));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && rdy2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected_ready: got fxp 0x%0h, required no result", out2);
      end else begin
        e = q2.pop_front();
        chk($sformatf("dut2_fxp[%08h]", e.op), longint'($signed(out2)), e.val);
        chk($sformatf("dut2_ovf[%08h]", e.op), longint'(ovf2), longint'(e.ovf));
        chk($sformatf("dut2_nan[%08h]", e.op), longint'(nan2), longint'(e.nan));
        chk($sformatf("dut2_latency[%08h]", e.op), cyc - e.acc, longint'(e.lat));
      end
    end
  end

  // Caller positions at a negedge; start is raised for exactly one edge.
  task automatic issue1(input logic [31:0] op, input bit expect_result);
    exp_t e;
    start1 = 1'b1; fin1 = op;
    @(posedge clk); #1;
    chk("dut1_busy_after_accept", longint'(busy1), 1);
    e = model(op, W1, F1, S1, R1);
    e.acc = cyc;
    if (expect_result) q1.push_back(e);
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic issue2(input logic [31:0] op);
    exp_t e;
    start2 = 1'b1; fin2 = op;
    @(posedge clk); #1;
    chk("dut2_busy_after_accept", longint'(busy2), 1);
    e = model(op, W2, F2, S2, R2);
    e.acc = cyc;
    q2.push_back(e);
    @(negedge clk); start2 = 1'b0;
  endtask

  task automatic drain1();
    int n = 0;
    while (q1.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("dut1_result_timeout_pending", longint'(q1.size()), 0);
    q1.delete();
  endtask

  task automatic drain2();
    int n = 0;
    while (q2.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("dut2_result_timeout_pending", longint'(q2.size()), 0);
    q2.delete();
  endtask

  // start held through A's run: B must be accepted on the edge that raises A's ready.
  task automatic b2b1(input logic [31:0] a, input logic [31:0] b);
    exp_t ea, eb;
    @(negedge clk);
    start1 = 1'b1; fin1 = a;
    @(posedge clk); #1;
    ea = model(a, W1, F1, S1, R1); ea.acc = cyc;
    eb = model(b, W1, F1, S1, R1); eb.acc = cyc + ea.lat;
    q1.push_back(ea); q1.push_back(eb);
    @(negedge clk); fin1 = b;
    while (cyc < eb.acc) @(negedge clk);
    start1 = 1'b0;
    drain1();
  endtask

  initial begin
    logic [31:0] dir1 [14];
    logic [31:0] dir2 [5];
    dir1 = '{32'h3F800000, 32'hC0200000, 32'h501502F9, 32'hFF800000,
             32'h37000000, 32'hB7000000, 32'h7FC00000, 32'h00000000,
             32'h80000000, 32'h7F800000, 32'h00000001, 32'hB3000000,
             32'h46FFFF00, 32'hC7000000};
    dir2 = '{32'h37000000, 32'h3F800000, 32'hC0200000, 32'h7FC00000, 32'hD6000000};

    #2;
    chk("reset_dut1_fxp",   longint'(out1),  0);
    chk("reset_dut1_ready", longint'(rdy1),  0);
    chk("reset_dut1_busy",  longint'(busy1), 0);
    chk("reset_dut1_ovf",   longint'(ovf1),  0);
    chk("reset_dut1_nan",   longint'(nan1),  0);
    chk("reset_dut2_fxp",   longint'(out2),  0);
    chk("reset_dut2_ready", longint'(rdy2),  0);
    chk("reset_dut2_busy",  longint'(busy2), 0);

    // Release and start on the same negedge: first edge after release accepts.
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue1(dir1[0], 1'b1);
    drain1();
    for (int i = 1; i < 14; i++) begin
      @(negedge clk); issue1(dir1[i], 1'b1); drain1();
    end

    // start pulse during SHIFT must be ignored.
    @(negedge clk); issue1(32'h3F800000, 1'b1);
    @(negedge clk); start1 = 1'b1; fin1 = 32'hC0200000;
    @(negedge clk); start1 = 1'b0;
    drain1();

    b2b1(32'h3F800000, 32'hC0200000);
    b2b1(32'h37000000, 32'h501502F9);

    // Reset during SHIFT aborts with no ready pulse.
    @(negedge clk); issue1(32'h3F800000, 1'b1); drain1();
    @(negedge clk); issue1(32'h3F800000, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("midreset_fxp",   longint'(out1),  0);
    chk("midreset_ready", longint'(rdy1),  0);
    chk("midreset_busy",  longint'(busy1), 0);
    chk("midreset_ovf",   longint'(ovf1),  0);
    chk("midreset_nan",   longint'(nan1),  0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue1(32'hC0200000, 1'b1);
    drain1();

    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i % 6 == 5) b2b1(rand_float(), rand_float());
      else begin issue1(rand_float(), 1'b1); drain1(); end
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge clk); issue2(dir2[i]); drain2();
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); issue2(rand_float()); drain2();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
